// File: rtl/md5_req_scheduler.sv
// md5_req_scheduler
// Shares one md5 hashing core among NUM_REQ requesters. Requests are granted round-robin.
// Only one job is in flight at a time. Each job runs through these steps:
//   1. latch the 128-bit block of the granted requester,
//   2. pulse the core load (start + action) for one cycle,
//   3. wait CORE_LAT cycles,
//   4. capture the core digest,
//   5. return the digest with the requester index over valid/ready.
//
// Ports
//   clk, rst        rising-edge clock; synchronous active-high reset
//   i_req_valid     per-requester job request
//   i_req_data      requester k block at [k*128 +: 128]
//   o_req_ready     one-hot grant, only while idle; transfer = valid & ready
//   o_core_start    core start, high only during the load cycle
//   o_core_action   core action, same timing as o_core_start
//   o_core_data     latched job block driven to the core
//   i_core_digest   core digest output
//   o_rsp_valid     captured digest available
//   i_rsp_ready     consumer accepts the response
//   o_rsp_digest    captured digest
//   o_rsp_id        index of the requester that owns o_rsp_digest
//   o_busy          high whenever a job is in progress
module md5_req_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned CORE_LAT = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [NUM_REQ*128-1:0] i_req_data,
  output logic [NUM_REQ-1:0]     o_req_ready,
  output logic                   o_core_start,
  output logic                   o_core_action,
  output logic [127:0]           o_core_data,
  input  logic [127:0]           i_core_digest,
  output logic                   o_rsp_valid,
  input  logic                   i_rsp_ready,
  output logic [127:0]           o_rsp_digest,
  output logic [ID_W-1:0]        o_rsp_id,
  output logic                   o_busy
);

  localparam int unsigned CntW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
  localparam logic [ID_W:0] NumReqW = (ID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;

  state_e              r_state;
  state_e              w_state_d;
  logic                r_core_start;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [CntW-1:0]     r_wait_cnt;
  logic [127:0]        r_data;
  logic [127:0]        r_digest;
  logic [ID_W-1:0]     r_id;

  logic                w_grant_vld;
  logic [ID_W-1:0]     w_grant_idx;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic [127:0]        w_grant_data;
  logic [ID_W:0]       w_sum;
  logic                w_wait_done;

  // Round-robin search.
  // The search starts at r_rr_ptr. The index wraps by subtraction, so NUM_REQ need not be
  // a power of two.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant_oh  = '0;
    w_sum       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W + 1)'(i);
      if (w_sum >= NumReqW) w_sum = w_sum - NumReqW;
      if (!w_grant_vld && i_req_valid[w_sum[ID_W-1:0]]) begin
        w_grant_vld             = 1'b1;
        w_grant_idx             = w_sum[ID_W-1:0];
        w_grant_oh[w_sum[ID_W-1:0]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant_idx == ID_W'(k)) w_grant_data = i_req_data[k*128 +: 128];
    end
  end

  assign w_wait_done = (r_wait_cnt == CntW'(CORE_LAT - 1));

  // State register.
  // The core load strobe is registered from the next state, so it is glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_core_start <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_core_start <= (w_state_d == StLoad);
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_grant_vld) w_state_d = StLoad;
      StLoad:  w_state_d = StWait;
      StWait:  if (w_wait_done) w_state_d = StResp;
      StResp:  if (i_rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    o_req_ready   = (r_state == StIdle) ? w_grant_oh : '0;
    o_core_start  = r_core_start;
    o_core_action = r_core_start;
    o_core_data   = r_data;
    o_rsp_valid   = (r_state == StResp);
    o_rsp_digest  = r_digest;
    o_rsp_id      = r_id;
    o_busy        = (r_state != StIdle);
  end

  // Job datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_wait_cnt <= '0;
      r_data     <= '0;
      r_digest   <= '0;
      r_id       <= '0;
    end else begin
      if (r_state == StIdle && w_grant_vld) begin
        r_data <= w_grant_data;
        r_id   <= w_grant_idx;
      end
      if (r_state == StLoad) begin
        r_wait_cnt <= '0;
      end else if (r_state == StWait) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (r_state == StWait && w_wait_done) r_digest <= i_core_digest;
      // The next search starts just after the requester that was served.
      if (r_state == StResp && i_rsp_ready) begin
        r_rr_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_md5_req_scheduler.sv
module tb_md5_req_scheduler;

  localparam int NUM_REQ  = 4;
  localparam int ID_W     = 2;
  localparam int CORE_LAT = 3;
  // Cycles after the accept cycle: 1 is the load cycle, RespAge is the response cycle.
  localparam int RespAge  = CORE_LAT + 2;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NUM_REQ-1:0]     i_req_valid = '0;
  logic [NUM_REQ*128-1:0] i_req_data;
  logic [NUM_REQ-1:0]     o_req_ready;
  logic                   o_core_start, o_core_action;
  logic [127:0]           o_core_data, core_digest;
  logic                   o_rsp_valid;
  logic                   i_rsp_ready = 1'b0;
  logic [127:0]           o_rsp_digest;
  logic [ID_W-1:0]        o_rsp_id;
  logic                   o_busy;

  logic [127:0] blk [NUM_REQ];
  logic [127:0] stub_s1, stub_s2;

  int checks = 0;
  int failures = 0;

  // Reference model: job age since accept, round-robin pointer, current job
  int           m_age = 0, m_ptr = 0, m_id = 0, m_grant = -1;
  logic [127:0] m_data = '0;
  logic [NUM_REQ-1:0] e_ready;
  logic         e_start, e_rsp, e_busy;

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) i_req_data[k*128 +: 128] = blk[k];
  end

  // Core stub: digest = ~data, two registers deep after the load strobe
  always @(posedge clk) begin
    if (o_core_start && o_core_action) stub_s1 <= ~o_core_data;
    stub_s2 <= stub_s1;
  end
  assign core_digest = stub_s2;

  md5_req_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CORE_LAT(CORE_LAT)) dut (
    .clk(clk), .rst(rst), .i_req_valid(i_req_valid), .i_req_data(i_req_data),
    .o_req_ready(o_req_ready), .o_core_start(o_core_start), .o_core_action(o_core_action),
    .o_core_data(o_core_data), .i_core_digest(core_digest), .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready), .o_rsp_digest(o_rsp_digest), .o_rsp_id(o_rsp_id),
    .o_busy(o_busy)
  );

  function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
    for (int i = 0; i < NUM_REQ; i++) if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NUM_REQ-1:0] x);
    for (int i = 0; i < NUM_REQ; i++) if (x[i]) return i;
    return -1;
  endfunction

  task automatic expect_now();
    int g;
    e_ready = '0; e_start = 1'b0; e_rsp = 1'b0; e_busy = (m_age != 0);
    if (m_age == 0) begin
      g = rr_pick(i_req_valid, m_ptr);
      if (g >= 0) e_ready[g] = 1'b1;
    end else if (m_age == 1) begin
      e_start = 1'b1;
    end else if (m_age >= RespAge) begin
      e_rsp = 1'b1;
    end
  endtask

  // Advance the model with the inputs of this cycle, then move to just after the edge
  task automatic tick();
    int g;
    m_grant = -1;
    if (rst) begin
      m_age = 0; m_ptr = 0;
    end else if (m_age == 0) begin
      g = rr_pick(i_req_valid, m_ptr);
      if (g >= 0) begin m_grant = g; m_id = g; m_data = blk[g]; m_age = 1; end
    end else if (m_age < RespAge) begin
      m_age++;
    end else if (i_rsp_ready) begin
      m_ptr = (m_id + 1) % NUM_REQ; m_age = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req_valid = '0; i_rsp_ready = 1'b0;
    repeat (2) begin @(negedge clk); tick(); end
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NUM_REQ; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
    do_reset();
    @(negedge clk);
    checks++;
    if (o_req_ready !== '0) begin failures++; $display("FAIL reset_ready got=%b exp=0", o_req_ready); end
    checks++;
    if ({o_core_start, o_core_action} !== 2'b00) begin
      failures++; $display("FAIL reset_core_strobe got=%b exp=00", {o_core_start, o_core_action});
    end
    checks++;
    if (o_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", o_rsp_valid); end
    checks++;
    if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", o_busy); end
    checks++;
    if (o_rsp_digest !== '0) begin failures++; $display("FAIL reset_digest got=%h exp=0", o_rsp_digest); end
    checks++;
    if (o_rsp_id !== '0) begin failures++; $display("FAIL reset_id got=%0d exp=0", o_rsp_id); end
    checks++;
    if (o_core_data !== '0) begin failures++; $display("FAIL reset_core_data got=%h exp=0", o_core_data); end
    tick();
  endtask

  task automatic test_single();
    logic [NUM_REQ-1:0] v;
    int acc, rsp, nrdy, nstart;
    do_reset();
    blk[0] = 128'h0123456789ABCDEF0123456789ABCDEF;
    v = 4'b0001; acc = -1; rsp = -1; nrdy = 0; nstart = 0; i_rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      i_req_valid = v;
      @(negedge clk); expect_now();
      checks++;
      if ({o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy} !==
          {e_ready, e_start, e_start, e_rsp, e_busy}) begin
        failures++;
        $display("FAIL single_ctl cyc=%0d got=%b exp=%b", c,
                 {o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy},
                 {e_ready, e_start, e_start, e_rsp, e_busy});
      end
      if (e_rsp) begin
        checks++;
        if ({o_rsp_digest, o_rsp_id} !== {~m_data, ID_W'(m_id)}) begin
          failures++;
          $display("FAIL single_rsp got=%h/%0d exp=%h/%0d", o_rsp_digest, o_rsp_id, ~m_data, m_id);
        end
      end
      if (o_req_ready != '0) nrdy++;
      if (o_core_start) nstart++;
      if ((o_req_ready & i_req_valid) != '0 && acc < 0) acc = c;
      if (o_rsp_valid && rsp < 0) rsp = c;
      tick();
      if (m_grant >= 0) v[m_grant] = 1'b0;
    end
    checks++;
    if (nrdy != 1) begin failures++; $display("FAIL single_ready_cycles got=%0d exp=1", nrdy); end
    checks++;
    if (nstart != 1) begin failures++; $display("FAIL single_start_cycles got=%0d exp=1", nstart); end
    checks++;
    if (acc < 0 || rsp - acc != CORE_LAT + 2) begin
      failures++; $display("FAIL single_latency got=%0d exp=%0d", rsp - acc, CORE_LAT + 2);
    end
  endtask

  task automatic test_back_to_back();
    int ids[$], cyc[$];
    int exp_ids[5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
    i_rsp_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      i_req_valid = '1;
      @(negedge clk); expect_now();
      checks++;
      if ({o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy} !==
          {e_ready, e_start, e_start, e_rsp, e_busy}) begin
        failures++;
        $display("FAIL b2b_ctl cyc=%0d got=%b exp=%b", c,
                 {o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy},
                 {e_ready, e_start, e_start, e_rsp, e_busy});
      end
      if (e_rsp) begin
        checks++;
        if ({o_rsp_digest, o_rsp_id} !== {~m_data, ID_W'(m_id)}) begin
          failures++;
          $display("FAIL b2b_rsp got=%h/%0d exp=%h/%0d", o_rsp_digest, o_rsp_id, ~m_data, m_id);
        end
      end
      if ((o_req_ready & i_req_valid) != '0) begin
        ids.push_back(oh_idx(o_req_ready)); cyc.push_back(c);
      end
      tick();
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (j >= ids.size() || ids[j] != exp_ids[j]) begin
        failures++;
        $display("FAIL b2b_order idx=%0d got=%0d exp=%0d", j,
                 (j < ids.size()) ? ids[j] : -1, exp_ids[j]);
      end
      if (j > 0 && j < cyc.size()) begin
        checks++;
        if (cyc[j] - cyc[j-1] != CORE_LAT + 3) begin
          failures++;
          $display("FAIL b2b_period idx=%0d got=%0d exp=%0d", j, cyc[j] - cyc[j-1], CORE_LAT + 3);
        end
      end
    end
  endtask

  task automatic test_rr_skip();
    logic [NUM_REQ-1:0] v;
    int ids[$];
    int exp_ids[4] = '{1, 3, 0, 1};
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
    v = 4'b0010; i_rsp_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (c == 6) v = v | 4'b1001;
      if (c == 9) v = v | 4'b0010;  // requester 1 arrives mid-job
      i_req_valid = v;
      @(negedge clk); expect_now();
      checks++;
      if ({o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy} !==
          {e_ready, e_start, e_start, e_rsp, e_busy}) begin
        failures++;
        $display("FAIL rr_ctl cyc=%0d got=%b exp=%b", c,
                 {o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy},
                 {e_ready, e_start, e_start, e_rsp, e_busy});
      end
      if (e_rsp) begin
        checks++;
        if ({o_rsp_digest, o_rsp_id} !== {~m_data, ID_W'(m_id)}) begin
          failures++;
          $display("FAIL rr_rsp got=%h/%0d exp=%h/%0d", o_rsp_digest, o_rsp_id, ~m_data, m_id);
        end
      end
      if ((o_req_ready & i_req_valid) != '0) ids.push_back(oh_idx(o_req_ready));
      tick();
      if (m_grant >= 0) v[m_grant] = 1'b0;
    end
    checks++;
    if (ids.size() != 4) begin failures++; $display("FAIL rr_grant_count got=%0d exp=4", ids.size()); end
    for (int j = 0; j < 4 && j < ids.size(); j++) begin
      checks++;
      if (ids[j] != exp_ids[j]) begin
        failures++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", j, ids[j], exp_ids[j]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [NUM_REQ-1:0] v;
    int hold, nvalid;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
    v = 4'b0100; hold = 0; nvalid = 0;
    for (int c = 0; c < 20; c++) begin
      if (m_age >= 1) v = '1;  // new requests while busy must stay pending
      if (m_age >= RespAge) hold++;
      i_rsp_ready = (hold > 10);
      i_req_valid = v;
      @(negedge clk); expect_now();
      checks++;
      if ({o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy} !==
          {e_ready, e_start, e_start, e_rsp, e_busy}) begin
        failures++;
        $display("FAIL bp_ctl cyc=%0d got=%b exp=%b", c,
                 {o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy},
                 {e_ready, e_start, e_start, e_rsp, e_busy});
      end
      if (e_rsp) begin
        checks++;
        if ({o_rsp_digest, o_rsp_id} !== {~m_data, ID_W'(m_id)}) begin
          failures++;
          $display("FAIL bp_rsp got=%h/%0d exp=%h/%0d", o_rsp_digest, o_rsp_id, ~m_data, m_id);
        end
      end
      if (o_rsp_valid) nvalid++;
      tick();
    end
    checks++;
    if (nvalid != 11) begin failures++; $display("FAIL bp_hold_cycles got=%0d exp=11", nvalid); end
  endtask

  task automatic test_reset_in_wait();
    logic [NUM_REQ-1:0] v;
    int g18, nrsp;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
    v = 4'b0010; i_rsp_ready = 1'b1; g18 = -1; nrsp = 0;
    for (int c = 0; c < 22; c++) begin
      if (c == 6) v = 4'b0100;
      if (c == 18) v = 4'b0110;
      rst = (c == 9);
      i_req_valid = v;
      @(negedge clk); expect_now();
      checks++;
      if ({o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy} !==
          {e_ready, e_start, e_start, e_rsp, e_busy}) begin
        failures++;
        $display("FAIL rstwait_ctl cyc=%0d got=%b exp=%b", c,
                 {o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy},
                 {e_ready, e_start, e_start, e_rsp, e_busy});
      end
      if (c > 6 && o_rsp_valid) nrsp++;
      if (c == 18 && (o_req_ready & i_req_valid) != '0) g18 = oh_idx(o_req_ready);
      tick();
      if (m_grant >= 0) v[m_grant] = 1'b0;
    end
    rst = 1'b0;
    checks++;
    if (nrsp != 0) begin failures++; $display("FAIL rstwait_no_rsp got=%0d exp=0", nrsp); end
    checks++;
    if (g18 != 1) begin failures++; $display("FAIL rstwait_grant got=%0d exp=1", g18); end
  endtask

  task automatic test_pulse_ignored();
    logic [NUM_REQ-1:0] v;
    int ngrant, nrsp;
    do_reset();
    for (int k = 0; k < NUM_REQ; k++) blk[k] = {$urandom, $urandom, $urandom, $urandom};
    v = 4'b0001; i_rsp_ready = 1'b1; ngrant = 0; nrsp = 0;
    for (int c = 0; c < 16; c++) begin
      i_req_valid = (c == 3) ? (v | 4'b0100) : v;
      @(negedge clk); expect_now();
      checks++;
      if ({o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy} !==
          {e_ready, e_start, e_start, e_rsp, e_busy}) begin
        failures++;
        $display("FAIL pulse_ctl cyc=%0d got=%b exp=%b", c,
                 {o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy},
                 {e_ready, e_start, e_start, e_rsp, e_busy});
      end
      if ((o_req_ready & i_req_valid) != '0) ngrant++;
      if (o_rsp_valid) nrsp++;
      tick();
      if (m_grant >= 0) v[m_grant] = 1'b0;
    end
    checks++;
    if (ngrant != 1) begin failures++; $display("FAIL pulse_grants got=%0d exp=1", ngrant); end
    checks++;
    if (nrsp != 1) begin failures++; $display("FAIL pulse_rsps got=%0d exp=1", nrsp); end
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] v;
    do_reset();
    v = '0;
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!v[k] && $urandom_range(0, 3) == 0) begin
          blk[k] = {$urandom, $urandom, $urandom, $urandom}; v[k] = 1'b1;
        end
      end
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      i_req_valid = v;
      @(negedge clk); expect_now();
      checks++;
      if ({o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy} !==
          {e_ready, e_start, e_start, e_rsp, e_busy}) begin
        failures++;
        $display("FAIL rand_ctl cyc=%0d got=%b exp=%b", c,
                 {o_req_ready, o_core_start, o_core_action, o_rsp_valid, o_busy},
                 {e_ready, e_start, e_start, e_rsp, e_busy});
      end
      if (e_rsp) begin
        checks++;
        if ({o_rsp_digest, o_rsp_id} !== {~m_data, ID_W'(m_id)}) begin
          failures++;
          $display("FAIL rand_rsp got=%h/%0d exp=%h/%0d", o_rsp_digest, o_rsp_id, ~m_data, m_id);
        end
      end
      tick();
      if (m_grant >= 0) v[m_grant] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_rr_skip();
    test_backpressure();
    test_reset_in_wait();
    test_pulse_ignored();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
